// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake for the UART transmitter's input FIFO.
interface uart_tx_fifo_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic              valid_i;
    logic [DATA_W-1:0] data_i;
    logic              ready_o;

    // Producer offers words; the transmitter returns space availability.
    modport master (output valid_i, output data_i, input ready_o);
    modport slave  (input valid_i, input data_i, output ready_o);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO: start, DATA_W data bits LSB first,
// optional parity, STOP_BITS stop bits; back-to-back frames with no idle gap.
module uart_tx_fifo #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    uart_tx_fifo_if.slave                 tx_if,
    input  logic                          parity_en_i,
    input  logic                          parity_odd_i,
    output logic                          serial_data_o,
    output logic                          busy_o,
    output logic                          char_sent_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t              state_q, state_n;
    logic [BAUD_W-1:0]   baud_q, baud_n;
    logic [BIT_W-1:0]    bit_q, bit_n;
    logic [DATA_W-1:0]   shift_q, shift_n;
    logic                par_en_q, par_en_n;
    logic                par_bit_q, par_bit_n;
    logic                serial_n;
    logic                char_sent_n;
    logic                start_c;
    logic                pop_c;
    logic                push_c;
    logic                bit_end_c;
    logic                last_stop_c;
    logic [DATA_W-1:0]   head_c;
    logic [CNT_W-1:0]    count_n;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

    assign push_c      = tx_if.valid_i & tx_if.ready_o;
    assign head_c      = mem_q[rd_ptr_q];
    assign bit_end_c   = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign last_stop_c = (bit_q == BIT_W'(STOP_BITS - 1));
    assign pop_c       = start_c;

    // Next FIFO occupancy; simultaneous push and pop cancel.
    always_comb begin
        count_n = fifo_count_o;
        if (push_c && !pop_c) begin
            count_n = fifo_count_o + CNT_W'(1);
        end else if (!push_c && pop_c) begin
            count_n = fifo_count_o - CNT_W'(1);
        end
    end

    // FIFO pointers, occupancy and registered space flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_count_o  <= '0;
            tx_if.ready_o <= 1'b1;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            fifo_count_o  <= count_n;
            tx_if.ready_o <= (count_n != CNT_W'(FIFO_DEPTH));
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_c) begin
            mem_q[wr_ptr_q] <= tx_if.data_i;
        end
    end

    // Frame sequencing: next state, bit timing and next line level.
    always_comb begin
        state_n     = state_q;
        baud_n      = '0;
        bit_n       = bit_q;
        shift_n     = shift_q;
        par_en_n    = par_en_q;
        par_bit_n   = par_bit_q;
        serial_n    = serial_data_o;
        char_sent_n = 1'b0;
        start_c     = 1'b0;

        if (state_q != IDLE) begin
            baud_n = bit_end_c ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (fifo_count_o != '0) start_c = 1'b1;
            end
            START: begin
                if (bit_end_c) begin
                    state_n  = DATA;
                    bit_n    = '0;
                    serial_n = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        bit_n = '0;
                        if (par_en_q) begin
                            state_n  = PARITY;
                            serial_n = par_bit_q;
                        end else begin
                            state_n  = STOP;
                            serial_n = 1'b1;
                        end
                    end else begin
                        bit_n    = bit_q + BIT_W'(1);
                        shift_n  = shift_q >> 1;
                        serial_n = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end_c) begin
                    state_n  = STOP;
                    bit_n    = '0;
                    serial_n = 1'b1;
                end
            end
            STOP: begin
                // Pulse is registered, so raise it one cycle ahead of the final stop cycle.
                if (last_stop_c && baud_q == BAUD_W'(CLKS_PER_BIT - 2)) char_sent_n = 1'b1;
                if (bit_end_c) begin
                    if (last_stop_c) begin
                        if (fifo_count_o != '0) begin
                            start_c = 1'b1;
                        end else begin
                            state_n  = IDLE;
                            serial_n = 1'b1;
                        end
                    end else begin
                        bit_n = bit_q + BIT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Pop the head and freeze parity settings for the whole frame.
        if (start_c) begin
            state_n   = START;
            baud_n    = '0;
            bit_n     = '0;
            shift_n   = head_c;
            par_en_n  = parity_en_i;
            par_bit_n = (^head_c) ^ parity_odd_i;
            serial_n  = 1'b0;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            baud_q        <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            par_en_q      <= 1'b0;
            par_bit_q     <= 1'b0;
            serial_data_o <= 1'b1;
            busy_o        <= 1'b0;
            char_sent_o   <= 1'b0;
        end else begin
            state_q       <= state_n;
            baud_q        <= baud_n;
            bit_q         <= bit_n;
            shift_q       <= shift_n;
            par_en_q      <= par_en_n;
            par_bit_q     <= par_bit_n;
            serial_data_o <= serial_n;
            busy_o        <= (state_n != IDLE);
            char_sent_o   <= char_sent_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level reference model checked every cycle,
// plus directed timing/boundary checks and a 2-stop-bit instance.
module tb_uart_tx_fifo;
    localparam int DW    = 8;
    localparam int CPB   = 4;
    localparam int NSTOP = 1;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       pen, podd;
    logic       line, busy, chr;
    logic [2:0] cnt;
    logic       line2, busy2, chr2;
    logic [2:0] cnt2;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_W(DW)) tx_if ();
    uart_tx_fifo_if #(.DATA_W(DW)) tx2_if ();

    uart_tx_fifo #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(NSTOP), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .tx_if(tx_if), .parity_en_i(pen), .parity_odd_i(podd),
        .serial_data_o(line), .busy_o(busy), .char_sent_o(chr), .fifo_count_o(cnt));

    uart_tx_fifo #(.DATA_W(DW), .CLKS_PER_BIT(16), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut2 (
        .clk_i(clk), .rst_i(rst), .tx_if(tx2_if), .parity_en_i(pen), .parity_odd_i(podd),
        .serial_data_o(line2), .busy_o(busy2), .char_sent_o(chr2), .fifo_count_o(cnt2));

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: pending words, and the current frame as a list of bit levels.
    logic [7:0] m_q [$];
    bit         m_lv [$];
    int         m_cyc;
    bit         m_act;
    bit         seen [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void load_frame(input logic [7:0] w, input logic pe, input logic po);
        m_lv.delete();
        m_lv.push_back(1'b0);
        for (int i = 0; i < DW; i++) m_lv.push_back(w[i]);
        if (pe) m_lv.push_back((^w) ^ po);
        for (int i = 0; i < NSTOP; i++) m_lv.push_back(1'b1);
        m_cyc = 0;
        m_act = 1'b1;
    endfunction

    // Advance one clock, step the model with the inputs seen at the edge, compare all outputs.
    task automatic tick();
        logic       push;
        logic [7:0] w;
        int         flen;
        logic       exp_line, exp_chr;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_act = 1'b0;
            m_cyc = 0;
        end else begin
            push = tx_if.valid_i && (m_q.size() != DEPTH);
            flen = m_lv.size() * CPB;
            if (m_act && m_cyc != flen - 1) begin
                m_cyc++;
            end else if (m_q.size() != 0) begin
                w = m_q.pop_front();
                load_frame(w, pen, podd);
            end else begin
                m_act = 1'b0;
            end
            if (push) m_q.push_back(tx_if.data_i);
        end
        #1;
        exp_line = m_act ? m_lv[m_cyc / CPB] : 1'b1;
        exp_chr  = m_act && (m_cyc == m_lv.size() * CPB - 1);
        check("line",  32'(line), 32'(exp_line));
        check("busy",  32'(busy), 32'(m_act));
        check("char",  32'(chr),  32'(exp_chr));
        check("count", 32'(cnt),  32'(m_q.size()));
        check("ready", 32'(tx_if.ready_o), 32'(m_q.size() != DEPTH));
    endtask

    // From the first start-bit cycle, record the line until char_sent_o (bounded).
    task automatic measure(input bit scramble, output int len, output int nbusy);
        len = 1;
        nbusy = busy ? 1 : 0;
        seen.delete();
        seen.push_back(line);
        while (!chr && len < 200) begin
            if (scramble) begin
                pen  = 1'($urandom);
                podd = 1'($urandom);
            end
            tick();
            len++;
            if (busy) nbusy++;
            seen.push_back(line);
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((busy || cnt != 0) && k < 1000) begin
            tick();
            k++;
        end
        check("drain_timeout", 32'(k < 1000), 32'(1));
    endtask

    task automatic send_one(input logic [7:0] w);
        tx_if.valid_i = 1'b1;
        tx_if.data_i  = w;
        tick();
        tx_if.valid_i = 1'b0;
        tick();
    endtask

    initial begin
        int   len, nb, acc, n, k, low, high, charpos, nb2, bad;
        int   acc_edge [6];
        logic pre, c_now, prev_chr;
        bit   exp_a5 [10];

        rst = 1'b1; pen = 1'b0; podd = 1'b0;
        tx_if.valid_i  = 1'b1; tx_if.data_i  = 8'h3C;
        tx2_if.valid_i = 1'b0; tx2_if.data_i = 8'h00;

        // Reset state, valid ignored during reset
        tick();
        check("rst_line",  32'(line), 32'(1));
        check("rst_ready", 32'(tx_if.ready_o), 32'(1));
        check("rst2_line", 32'(line2), 32'(1));
        check("rst2_busy", 32'(busy2), 32'(0));
        check("rst2_cnt",  32'(cnt2), 32'(0));
        check("rst2_ready", 32'(tx2_if.ready_o), 32'(1));
        tick();
        tx_if.valid_i = 1'b0;
        rst = 1'b0;
        tick();
        check("rst_no_write", 32'(cnt), 32'(0));

        // 0xA5 no parity: latency, waveform, length
        tx_if.valid_i = 1'b1; tx_if.data_i = 8'hA5;
        tick();
        check("lat_cnt",  32'(cnt), 32'(1));
        check("lat_idle", 32'(line), 32'(1));
        tx_if.valid_i = 1'b0;
        tick();
        check("lat_start", 32'(line), 32'(0));
        measure(1'b0, len, nb);
        check("a5_len",  32'(len), 32'(40));
        check("a5_busy", 32'(nb),  32'(40));
        exp_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        for (int b = 0; b < 10; b++) check("a5_bit", 32'(seen[b * CPB + 2]), 32'(exp_a5[b]));
        tick();
        check("a5_idle", 32'(busy), 32'(0));

        // 0x07 even then odd parity; parity inputs scrambled mid-frame
        pen = 1'b1; podd = 1'b0;
        send_one(8'h07);
        measure(1'b1, len, nb);
        check("even_len", 32'(len), 32'(44));
        check("even_par", 32'(seen[9 * CPB + 2]), 32'(1));
        pen = 1'b1; podd = 1'b1;
        tick();
        send_one(8'h07);
        measure(1'b1, len, nb);
        check("odd_len", 32'(len), 32'(44));
        check("odd_par", 32'(seen[9 * CPB + 2]), 32'(0));
        pen = 1'b0; podd = 1'b0;
        drain();

        // Continuous valid with 0x10..0x15
        tx_if.valid_i = 1'b1; tx_if.data_i = 8'h10;
        acc = 0; n = 0; prev_chr = 1'b0;
        while (acc < 6 && n < 400) begin
            pre   = tx_if.ready_o;
            c_now = chr;
            tick();
            n++;
            if (pre) begin
                if (acc == 5) check("q15_after_char", 32'(prev_chr), 32'(1));
                acc_edge[acc] = n;
                acc++;
                tx_if.data_i = 8'(8'h10 + acc);
                if (acc == 5) check("ready_fall", 32'(tx_if.ready_o), 32'(0));
                if (acc == 6) tx_if.valid_i = 1'b0;
            end
            prev_chr = c_now;
        end
        check("acc_total", 32'(acc), 32'(6));
        check("acc5_edge", 32'(acc_edge[4]), 32'(5));
        check("acc6_edge", 32'(acc_edge[5]), 32'(43));
        drain();

        // Push while popping at count 2
        tx_if.valid_i = 1'b1;
        tx_if.data_i = 8'h5A; tick();
        tx_if.data_i = 8'hC3; tick();
        tx_if.data_i = 8'h81; tick();
        tx_if.valid_i = 1'b0;
        check("pp_cnt2", 32'(cnt), 32'(2));
        k = 0;
        while (!chr && k < 100) begin tick(); k++; end
        tx_if.valid_i = 1'b1; tx_if.data_i = 8'h3E;
        tick();
        tx_if.valid_i = 1'b0;
        check("pushpop_cnt", 32'(cnt), 32'(2));
        drain();

        // Reset during data bit 3 with two words queued
        tx_if.valid_i = 1'b1;
        tx_if.data_i = 8'hF0; tick();
        tx_if.data_i = 8'h0F; tick();
        tx_if.data_i = 8'h99; tick();
        tx_if.valid_i = 1'b0;
        repeat (16) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_line", 32'(line), 32'(1));
        check("mrst_busy", 32'(busy), 32'(0));
        check("mrst_cnt",  32'(cnt),  32'(0));
        check("mrst_char", 32'(chr),  32'(0));
        bad = 0;
        repeat (60) begin
            tick();
            if (busy || chr) bad++;
        end
        check("mrst_quiet", 32'(bad), 32'(0));

        // Randomized traffic with parity settings changing every cycle
        for (int i = 0; i < 1500; i++) begin
            tx_if.valid_i = ($urandom_range(0, 3) == 0);
            tx_if.data_i  = 8'($urandom);
            pen           = 1'($urandom);
            podd          = 1'($urandom);
            tick();
        end
        tx_if.valid_i = 1'b0;
        drain();

        // Two stop bits, 16 clocks per bit, 0x00
        pen = 1'b0; podd = 1'b0;
        tx2_if.valid_i = 1'b1; tx2_if.data_i = 8'h00;
        tick();
        tx2_if.valid_i = 1'b0;
        low = 0; high = 0; charpos = 0; nb2 = 0; k = 0;
        while ((nb2 == 0 || busy2) && k < 400) begin
            tick();
            k++;
            if (busy2) begin
                nb2++;
                if (line2) high++; else low++;
                if (chr2) charpos = nb2;
            end
        end
        check("s2_low",  32'(low),     32'(144));
        check("s2_high", 32'(high),    32'(32));
        check("s2_len",  32'(nb2),     32'(176));
        check("s2_char", 32'(charpos), 32'(176));
        check("s2_idle", 32'(line2),   32'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 8, sets the data bits per frame; legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 16, sets the clk_i cycles per serial bit; legal range 2..65535.
REQ-003 Parameter STOP_BITS, default 1, sets the stop bits per frame; legal values 1 or 2.
REQ-004 Parameter FIFO_DEPTH, default 4, sets the number of queued words; must be a power of 2, at least 2.
REQ-005 Port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port valid_i, input, 1 bit: data_i is offered.
REQ-008 Port data_i, input, DATA_W bits: word to transmit, LSB sent first.
REQ-009 Port ready_o, output, 1 bit: FIFO not full; a word is accepted on any edge where valid_i and ready_o are both 1.
REQ-010 Port parity_en_i, input, 1 bit: insert a parity bit after the data bits.
REQ-011 Port parity_odd_i, input, 1 bit: 1 selects odd parity, 0 selects even parity.
REQ-012 Port serial_data_o, output, 1 bit: registered serial line, idle level 1.
REQ-013 Port busy_o, output, 1 bit: a frame is in progress, i.e. FSM state is not IDLE.
REQ-014 Port char_sent_o, output, 1 bit: one-cycle pulse when a frame's last stop bit completes.
REQ-015 Port fifo_count_o, output, clog2(FIFO_DEPTH)+1 bits: number of words queued, excluding the word being shifted.

Function
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY and STOP; each bit period SHALL be held for exactly CLKS_PER_BIT cycles, timed by an internal baud counter that reloads at every bit boundary.
REQ-017 In IDLE with fifo_count_o>0, the next edge SHALL pop the FIFO head, load the shifter, latch parity_en_i and parity_odd_i, enter START, and drive serial_data_o=0.
REQ-018 Latency: a word accepted at edge T into an empty FIFO with the FSM in IDLE SHALL drive the start bit from edge T+1.
REQ-019 Transitions: START goes to DATA; DATA goes to PARITY after DATA_W bits if parity was latched, otherwise to STOP; PARITY goes to STOP; STOP goes to START after STOP_BITS bit periods if the FIFO is non-empty, otherwise to IDLE.
REQ-020 Parity bit = XOR of the data bits, XORed with the latched parity_odd value.
REQ-021 Changes to parity_en_i or parity_odd_i mid-frame SHALL NOT affect the current frame.
REQ-022 Back-to-back frames SHALL have zero idle cycles: the next start bit begins on the cycle after the last stop-bit cycle.
REQ-023 char_sent_o SHALL pulse high for 1 cycle, coincident with the final cycle of the last stop bit.
REQ-024 ready_o = (fifo_count_o != FIFO_DEPTH).
REQ-025 valid_i while ready_o=0 SHALL be ignored: no write, and FIFO contents unchanged.
REQ-026 A push and a pop on the same edge SHALL leave fifo_count_o unchanged and SHALL preserve order.
REQ-027 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; count arithmetic SHALL not overflow or underflow.

Reset
REQ-028 On the first edge with rst_i=1, the block SHALL set state=IDLE, serial_data_o=1, busy_o=0, char_sent_o=0, ready_o=1, fifo_count_o=0, baud counter=0 and FIFO pointers=0.
REQ-029 Reset mid-frame SHALL abort the frame, return the line to 1 on the next edge, discard queued words, and suppress char_sent_o.
REQ-030 While rst_i=1, valid_i SHALL be ignored.

Verification (DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1, FIFO_DEPTH=4 unless stated)
REQ-031 Send 0xA5, parity off -> line 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; char_sent_o pulses on cycle 40 after the start; busy_o is 1 for 40 cycles.
REQ-032 Send 0x07 with even parity -> parity bit 1; send 0x07 with odd parity -> parity bit 0; each frame is 44 cycles long.
REQ-033 Assert valid_i continuously with words 0x10..0x15 -> 0x10..0x14 are accepted on consecutive edges, ready_o falls after the 5th acceptance, 0x15 is accepted the cycle after the first char_sent_o, and frames run back-to-back with no gaps.
REQ-034 Push while popping at fifo_count_o=2 -> count stays 2 and output order is preserved.
REQ-035 Assert rst_i during data bit 3 of a frame with 2 words queued -> the next cycle has line=1, busy_o=0, fifo_count_o=0, no char_sent_o pulse, and no further frames.
REQ-036 STOP_BITS=2, CLKS_PER_BIT=16, send 0x00 -> stop-high lasts 32 cycles and the frame is 176 cycles long.
